// File: rtl/hpm_counter_ext_if.sv
// CSR access channel between the priv CSR file (master) and an extension responder.
// The ext modport is the responder view and is identical to slave.
interface priv_ext_if;
  logic [11:0] csr_addr;
  logic [31:0] value_in;
  logic        csr_active;
  logic        ack;
  logic [31:0] value_out;
  logic        invalid_csr;

  modport master (output csr_addr, value_in, csr_active,
                  input  ack, value_out, invalid_csr);
  modport slave  (input  csr_addr, value_in, csr_active,
                  output ack, value_out, invalid_csr);
  modport ext    (input  csr_addr, value_in, csr_active,
                  output ack, value_out, invalid_csr);
endinterface

// File: rtl/hpm_counter_ext.sv
// HPM extension CSR file: mhpmcounter3.. with event selects, user read-only shadows
// and per-counter wrap pulses.
module hpm_counter_ext #(
  parameter int unsigned NUM_COUNTERS = 4,
  parameter int unsigned EVENT_W      = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  priv_ext_if.ext                 prv_ext,
  input  logic [EVENT_W-1:0]      events,
  input  logic [NUM_COUNTERS-1:0] hpm_inhibit,
  output logic [NUM_COUNTERS-1:0] hpm_overflow
);

  localparam int unsigned SEL_W = $clog2(EVENT_W + 1);
  localparam int unsigned PAD_W = 1 << SEL_W;

  logic [63:0]             cnt_q [NUM_COUNTERS];
  logic [63:0]             cnt_d [NUM_COUNTERS];
  logic [SEL_W-1:0]        sel_q [NUM_COUNTERS];
  logic [SEL_W-1:0]        sel_d [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0] ovf_q, ovf_d;

  logic [NUM_COUNTERS-1:0] hit_lo, hit_hi, hit_ev, hit_ulo, hit_uhi;
  logic [NUM_COUNTERS-1:0] inc;
  logic [PAD_W-1:0]        ev_pad;
  logic                    wr_en;

  // Address decode and read mux; active during reset as well
  always_comb begin
    hit_lo  = '0;
    hit_hi  = '0;
    hit_ev  = '0;
    hit_ulo = '0;
    hit_uhi = '0;
    prv_ext.value_out = '0;
    for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
      hit_lo[i]  = (prv_ext.csr_addr == 12'(32'h0B03 + i));
      hit_hi[i]  = (prv_ext.csr_addr == 12'(32'h0B83 + i));
      hit_ev[i]  = (prv_ext.csr_addr == 12'(32'h0323 + i));
      hit_ulo[i] = (prv_ext.csr_addr == 12'(32'h0C03 + i));
      hit_uhi[i] = (prv_ext.csr_addr == 12'(32'h0C83 + i));
      if (hit_lo[i] || hit_ulo[i]) prv_ext.value_out = cnt_q[i][31:0];
      if (hit_hi[i] || hit_uhi[i]) prv_ext.value_out = cnt_q[i][63:32];
      if (hit_ev[i])               prv_ext.value_out = 32'(sel_q[i]);
    end
    prv_ext.ack         = |{hit_lo, hit_hi, hit_ev, hit_ulo, hit_uhi};
    prv_ext.invalid_csr = prv_ext.csr_active & (|{hit_ulo, hit_uhi});
    wr_en               = prv_ext.csr_active & prv_ext.ack & ~prv_ext.invalid_csr;
  end

  // Select 0 maps to the constant-zero pad bit, so "no event" needs no special case
  always_comb begin
    ev_pad = '0;
    ev_pad[EVENT_W:1] = events;
    inc    = '0;
    ovf_d  = '0;
    for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
      cnt_d[i] = cnt_q[i];
      sel_d[i] = sel_q[i];
      inc[i]   = ev_pad[sel_q[i]] & ~hpm_inhibit[i];
      if (wr_en && hit_lo[i]) begin
        cnt_d[i][31:0] = prv_ext.value_in;
      end else if (wr_en && hit_hi[i]) begin
        // Low half keeps counting; its carry is discarded by the high write
        cnt_d[i][31:0]  = cnt_q[i][31:0] + 32'(inc[i]);
        cnt_d[i][63:32] = prv_ext.value_in;
      end else if (inc[i]) begin
        cnt_d[i] = cnt_q[i] + 64'd1;
        ovf_d[i] = &cnt_q[i];
      end
      if (wr_en && hit_ev[i]) begin
        sel_d[i] = (prv_ext.value_in <= 32'(EVENT_W)) ? prv_ext.value_in[SEL_W-1:0] : '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
        cnt_q[i] <= '0;
        sel_q[i] <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
        cnt_q[i] <= cnt_d[i];
        sel_q[i] <= sel_d[i];
      end
      ovf_q <= ovf_d;
    end
  end

  assign hpm_overflow = ovf_q;

endmodule
